preamble_search_ctrl: RTL and testbench
=======================================

Name: preamble_search_ctrl

Overview:
- Sequences one preamble search on the bank correlator: flushes it, arms on `start`, scans every bank score per valid sample, tracks the peak, and reports the winning bank, score and sample index.
- Sits between the correlator output and the downstream frame decoder; the decoder uses `det_offset` to align bit slicing.
- Reports a timeout if no detection occurs within a window.

Parameters:
- LENGTH, 64, correlator shift-register length; sets CORR_WIDTH = $clog2(LENGTH+1) (7 at default)
- BANKS, 16, number of correlator banks; BANK_W = $clog2(BANKS)
- HOLD, 8, valid samples with no new maximum before a peak is declared
- FLUSH_CYCLES, 4, cycles `corr_rst` is held high to clear the correlator pipeline
- CNT_W, 16, width of the sample counter and the timeout field

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous assert, active-low
- start  in  1  single-cycle pulse; begins a search; ignored unless in IDLE
- abort  in  1  return to IDLE from any state
- threshold  in  CORR_WIDTH  minimum score to qualify; sampled at `start`
- timeout_len  in  CNT_W  max valid samples to search; 0 means no timeout; sampled at `start`
- corr_dat  in  CORR_WIDTH*BANKS  packed bank scores, bank i at [i*CORR_WIDTH +: CORR_WIDTH]
- corr_vld  in  1  `corr_dat` valid
- all_zeros  in  1  correlator quiet indicator
- corr_rst  out  1  synchronous reset to the correlator
- busy  out  1  high in any state except IDLE
- det_vld  out  1  one-cycle detection pulse
- det_bank  out  BANK_W  winning bank
- det_score  out  CORR_WIDTH  winning score
- det_offset  out  CNT_W  valid-sample index of the peak, counted from the first sample after FLUSH
- timeout  out  1  one-cycle pulse, no detection

Behaviour:
- Reset: all outputs 0; state IDLE; counters and registers 0.
- Argmax stage (1 register):
  - Each `corr_vld` cycle, select the maximum bank score; lowest index wins ties.
  - Register score, bank and the sample count; the registered valid is `am_vld`.
  - All downstream logic uses `am_vld` only.
- FSM states: IDLE, FLUSH, SEARCH, TRACK, REPORT.
- IDLE:
  - On `start`, latch `threshold` and `timeout_len`, then go to FLUSH.
  - FLUSH drives `corr_rst` = 1 for FLUSH_CYCLES cycles, clears `sample_cnt` and discards the argmax register, then goes to SEARCH.
- SEARCH:
  - On `am_vld` with score >= threshold, store best = (score, bank, cnt), clear `hold_cnt`, go to TRACK.
  - Otherwise, if `timeout_len` != 0 and `sample_cnt` reaches `timeout_len`, pulse `timeout` and go to IDLE.
- TRACK, on `am_vld`:
  - Score > best.score (strictly greater): replace best, `hold_cnt` = 0.
  - Otherwise `hold_cnt` += 1.
  - When `hold_cnt` reaches HOLD, go to REPORT.
  - Timeout is not checked in TRACK; a found peak always reports.
- REPORT: drive `det_vld` = 1 with best for one cycle, then go to IDLE.
- Counter rules:
  - `sample_cnt` increments on each `corr_vld` in SEARCH/TRACK and saturates at all-ones.
  - Comparisons are unsigned.
- `abort` has priority over every transition:
  - Go to IDLE next cycle; no `det_vld` or `timeout` pulse.
  - `corr_rst` deasserts immediately.
- `start` while busy: ignored.
- `start` and `abort` in the same cycle in IDLE: `abort` wins, remain in IDLE.
- `corr_vld` during FLUSH: ignored.
- Reset mid-search: immediate IDLE; outputs 0.

Optional Feature:
- Macro: PREAMBLE_SEARCH_QUIET_GATE_EN.
- Defined:
  - After FLUSH, SEARCH ignores threshold crossings until `all_zeros` has been high on at least one `corr_vld` sample.
  - Prevents locking onto a mid-frame tail.
  - Samples before that point still count toward timeout.
- Undefined: `all_zeros` is unused and SEARCH qualifies immediately.

Decomposition:
- Shared package `preamble_pkg`:
  - CORR_WIDTH/BANK_W derivation functions.
  - FSM state enum.
  - Bank slice helper.
- One sub-module: `bank_argmax`, a combinational max tree with lowest-index tie break; the controller registers its output.

Test Plan:
- Tie-break: bank 3 = 40 and bank 9 = 40, all others below, threshold = 30, HOLD = 8, then 8 samples with score 20 → `det_vld` with `det_bank` = 3, `det_score` = 40.
- Peak climb: scores rise 31, 35, 50 at samples 10, 11, 12 on bank 5, then 8 samples below 50 → `det_score` = 50, `det_bank` = 5, `det_offset` = 12.
- Timeout: `timeout_len` = 100, all scores below threshold → `timeout` pulse once 100 valid samples have been counted (`sample_cnt` reaches 100), `det_vld` never asserted, back to IDLE.
- Abort in TRACK after 3 hold samples → no `det_vld`/`timeout`; `busy` = 0 the next cycle; a subsequent `start` completes normally.
- Flush/reset: `corr_rst` high exactly FLUSH_CYCLES = 4 cycles after `start`; `rst_n` low mid-TRACK → all outputs 0 immediately.
- With PREAMBLE_SEARCH_QUIET_GATE_EN defined, an above-threshold score before any `all_zeros` is ignored, and the same score after `all_zeros` is seen enters TRACK.

Source files
------------

// File: rtl/preamble_pkg.sv
// Shared types and helpers for the preamble search controller.
package preamble_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FLUSH  = 3'd1,
    ST_SEARCH = 3'd2,
    ST_TRACK  = 3'd3,
    ST_REPORT = 3'd4
  } state_e;

  // Width needed to hold a correlator score in the range 0..length.
  function automatic int corr_width_f(input int length);
    return $clog2(length + 1);
  endfunction

  // Width of a bank index; a single bank still gets a one-bit field.
  function automatic int bank_w_f(input int banks);
    return (banks > 1) ? $clog2(banks) : 1;
  endfunction

  // Low bit position of bank idx inside the packed score bus.
  function automatic int bank_lo(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/preamble_search_ctrl_bank_argmax.sv
// bank_argmax: combinational maximum over all bank scores.
// Ties resolve to the lowest bank index because a later bank must be
// strictly greater to displace the current winner.
module bank_argmax
  import preamble_pkg::*;
#(
  parameter int CORR_W = 7,
  parameter int BANKS  = 16,
  parameter int BANK_W = 4
) (
  input  logic [CORR_W*BANKS-1:0] dat_i,
  output logic [CORR_W-1:0]       max_score_o,
  output logic [BANK_W-1:0]       max_bank_o
);

  // Compare chain from bank 0 upward; strict compare keeps the lowest index on ties.
  always_comb begin
    max_score_o = dat_i[0 +: CORR_W];
    max_bank_o  = '0;
    for (int i = 1; i < BANKS; i++) begin
      if (dat_i[bank_lo(i, CORR_W) +: CORR_W] > max_score_o) begin
        max_score_o = dat_i[bank_lo(i, CORR_W) +: CORR_W];
        max_bank_o  = BANK_W'(i);
      end
    end
  end

endmodule

// File: rtl/preamble_search_ctrl.sv
// preamble_search_ctrl: flushes the bank correlator, searches for a score
// above threshold, tracks the peak until it has held for HOLD samples and
// reports bank/score/offset, or reports a timeout.
// Optional build macro PREAMBLE_SEARCH_QUIET_GATE_EN: qualification is held
// off until all_zeros has been seen on a valid sample after the flush.
module preamble_search_ctrl
  import preamble_pkg::*;
#(
  parameter  int LENGTH       = 64,
  parameter  int BANKS        = 16,
  parameter  int HOLD         = 8,
  parameter  int FLUSH_CYCLES = 4,
  parameter  int CNT_W        = 16,
  localparam int CORR_WIDTH   = corr_width_f(LENGTH),
  localparam int BANK_W       = bank_w_f(BANKS)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        abort,
  input  logic [CORR_WIDTH-1:0]       threshold,
  input  logic [CNT_W-1:0]            timeout_len,
  input  logic [CORR_WIDTH*BANKS-1:0] corr_dat,
  input  logic                        corr_vld,
  input  logic                        all_zeros,
  output logic                        corr_rst,
  output logic                        busy,
  output logic                        det_vld,
  output logic [BANK_W-1:0]           det_bank,
  output logic [CORR_WIDTH-1:0]       det_score,
  output logic [CNT_W-1:0]            det_offset,
  output logic                        timeout
);

  localparam int HOLD_W  = $clog2(HOLD + 1);
  localparam int FLUSH_W = $clog2(FLUSH_CYCLES + 1);

  state_e state_q, state_d;

  logic [CORR_WIDTH-1:0] max_score;
  logic [BANK_W-1:0]     max_bank;

  logic                  am_vld_q, am_vld_d;
  logic [CORR_WIDTH-1:0] am_score_q, am_score_d;
  logic [BANK_W-1:0]     am_bank_q, am_bank_d;
  logic [CNT_W-1:0]      am_cnt_q, am_cnt_d;

  logic [CNT_W-1:0]      sample_cnt_q, sample_cnt_d;
  logic [FLUSH_W-1:0]    flush_cnt_q, flush_cnt_d;
  logic [HOLD_W-1:0]     hold_cnt_q, hold_cnt_d;
  logic [CORR_WIDTH-1:0] thr_q, thr_d;
  logic [CNT_W-1:0]      tlen_q, tlen_d;
  logic [CORR_WIDTH-1:0] best_score_q, best_score_d;
  logic [BANK_W-1:0]     best_bank_q, best_bank_d;
  logic [CNT_W-1:0]      best_cnt_q, best_cnt_d;

  logic in_scan, gate_ok, qualify, greater, hold_done, flush_last, tmo_hit;

  bank_argmax #(
    .CORR_W (CORR_WIDTH),
    .BANKS  (BANKS),
    .BANK_W (BANK_W)
  ) u_argmax (
    .dat_i       (corr_dat),
    .max_score_o (max_score),
    .max_bank_o  (max_bank)
  );

`ifdef PREAMBLE_SEARCH_QUIET_GATE_EN
  logic quiet_seen_q, quiet_seen_d;

  // Remember whether the correlator has gone quiet since the flush.
  always_comb begin
    quiet_seen_d = quiet_seen_q;
    if (state_q == ST_FLUSH)
      quiet_seen_d = 1'b0;
    else if (in_scan && corr_vld && all_zeros)
      quiet_seen_d = 1'b1;
  end

  // Quiet-seen flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) quiet_seen_q <= 1'b0;
    else        quiet_seen_q <= quiet_seen_d;
  end

  assign gate_ok = quiet_seen_q;
`else
  logic unused_all_zeros;
  assign unused_all_zeros = all_zeros;
  assign gate_ok          = 1'b1;
`endif

  assign in_scan    = (state_q == ST_SEARCH) || (state_q == ST_TRACK);
  assign qualify    = am_vld_q && gate_ok && (am_score_q >= thr_q);
  assign greater    = am_vld_q && (am_score_q > best_score_q);
  assign hold_done  = am_vld_q && !greater && (hold_cnt_q == HOLD_W'(HOLD - 1));
  assign flush_last = (flush_cnt_q == FLUSH_W'(FLUSH_CYCLES - 1));
  assign tmo_hit    = (tlen_q != '0) && (sample_cnt_q >= tlen_q);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; abort overrides every transition.
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE:   if (start) state_d = ST_FLUSH;
        ST_FLUSH:  if (flush_last) state_d = ST_SEARCH;
        ST_SEARCH: if (qualify) state_d = ST_TRACK;
                   else if (tmo_hit) state_d = ST_IDLE;
        ST_TRACK:  if (hold_done) state_d = ST_REPORT;
        ST_REPORT: state_d = ST_IDLE;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  // Output decode; pulses are suppressed in the cycle abort is seen.
  always_comb begin
    corr_rst   = (state_q == ST_FLUSH) && !abort;
    busy       = (state_q != ST_IDLE);
    det_vld    = 1'b0;
    det_bank   = '0;
    det_score  = '0;
    det_offset = '0;
    timeout    = (state_q == ST_SEARCH) && !abort && !qualify && tmo_hit;
    if (state_q == ST_REPORT && !abort) begin
      det_vld    = 1'b1;
      det_bank   = best_bank_q;
      det_score  = best_score_q;
      det_offset = best_cnt_q;
    end
  end

  // Datapath next-state: argmax stage, counters, latched config and best peak.
  always_comb begin
    am_vld_d     = 1'b0;
    am_score_d   = am_score_q;
    am_bank_d    = am_bank_q;
    am_cnt_d     = am_cnt_q;
    sample_cnt_d = sample_cnt_q;
    flush_cnt_d  = '0;
    hold_cnt_d   = hold_cnt_q;
    thr_d        = thr_q;
    tlen_d       = tlen_q;
    best_score_d = best_score_q;
    best_bank_d  = best_bank_q;
    best_cnt_d   = best_cnt_q;

    if (in_scan && corr_vld) begin
      am_vld_d   = 1'b1;
      am_score_d = max_score;
      am_bank_d  = max_bank;
      am_cnt_d   = sample_cnt_q;
      if (sample_cnt_q != {CNT_W{1'b1}})
        sample_cnt_d = sample_cnt_q + CNT_W'(1);
    end

    if (state_q == ST_FLUSH) begin
      sample_cnt_d = '0;
      flush_cnt_d  = flush_cnt_q + FLUSH_W'(1);
    end

    if (state_q == ST_IDLE && start && !abort) begin
      thr_d  = threshold;
      tlen_d = timeout_len;
    end

    if ((state_q == ST_SEARCH && qualify) || (state_q == ST_TRACK && greater)) begin
      best_score_d = am_score_q;
      best_bank_d  = am_bank_q;
      best_cnt_d   = am_cnt_q;
      hold_cnt_d   = '0;
    end else if (state_q == ST_TRACK && am_vld_q) begin
      hold_cnt_d = hold_cnt_q + HOLD_W'(1);
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      am_vld_q     <= 1'b0;
      am_score_q   <= '0;
      am_bank_q    <= '0;
      am_cnt_q     <= '0;
      sample_cnt_q <= '0;
      flush_cnt_q  <= '0;
      hold_cnt_q   <= '0;
      thr_q        <= '0;
      tlen_q       <= '0;
      best_score_q <= '0;
      best_bank_q  <= '0;
      best_cnt_q   <= '0;
    end else begin
      am_vld_q     <= am_vld_d;
      am_score_q   <= am_score_d;
      am_bank_q    <= am_bank_d;
      am_cnt_q     <= am_cnt_d;
      sample_cnt_q <= sample_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
      hold_cnt_q   <= hold_cnt_d;
      thr_q        <= thr_d;
      tlen_q       <= tlen_d;
      best_score_q <= best_score_d;
      best_bank_q  <= best_bank_d;
      best_cnt_q   <= best_cnt_d;
    end
  end

endmodule

// File: tb/tb_preamble_search_ctrl.sv
// Bench for preamble_search_ctrl: directed scenarios described as per-period
// sample tables, an event-level model deriving the expected output timeline,
// a per-cycle compare process and hand-computed literal expectations.
module tb_preamble_search_ctrl;

  localparam int CW   = 7;
  localparam int NB   = 16;
  localparam int BW   = 4;
  localparam int CNTW = 16;
  localparam int FL   = 4;
  localparam int HLD  = 8;
  localparam int NPM  = 128;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic              abort;
  logic [CW-1:0]     threshold;
  logic [CNTW-1:0]   timeout_len;
  logic [CW*NB-1:0]  corr_dat;
  logic              corr_vld;
  logic              all_zeros;
  logic              corr_rst;
  logic              busy;
  logic              det_vld;
  logic [BW-1:0]     det_bank;
  logic [CW-1:0]     det_score;
  logic [CNTW-1:0]   det_offset;
  logic              timeout;

  preamble_search_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .abort       (abort),
    .threshold   (threshold),
    .timeout_len (timeout_len),
    .corr_dat    (corr_dat),
    .corr_vld    (corr_vld),
    .all_zeros   (all_zeros),
    .corr_rst    (corr_rst),
    .busy        (busy),
    .det_vld     (det_vld),
    .det_bank    (det_bank),
    .det_score   (det_score),
    .det_offset  (det_offset),
    .timeout     (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Scenario tables, indexed by period relative to the start pulse (period 0).
  bit vld [NPM];
  bit az  [NPM];
  int lo  [NPM];
  int b1  [NPM];
  int s1  [NPM];
  int b2  [NPM];
  int s2  [NPM];
  int abort_p;

  // Expected timeline.
  bit exp_busy [NPM];
  bit exp_crst [NPM];
  bit exp_det  [NPM];
  bit exp_tmo  [NPM];
  int exp_bank, exp_score, exp_off;

  int per;
  bit checking = 1'b0;
  int det_count, tmo_count, tmo_per, cap_bank, cap_score, cap_off;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int score_of(input int p, input int b);
    if (b == b1[p]) return s1[p];
    if (b == b2[p]) return s2[p];
    return lo[p];
  endfunction

  function automatic logic [CW*NB-1:0] mkdat(input int p);
    logic [CW*NB-1:0] d;
    d = '0;
    for (int b = 0; b < NB; b++) d[b*CW +: CW] = CW'(score_of(p, b));
    return d;
  endfunction

  task automatic clr_scn();
    for (int p = 0; p < NPM; p++) begin
      vld[p] = 0; az[p] = 0; lo[p] = 0;
      b1[p] = -1; s1[p] = 0; b2[p] = -1; s2[p] = 0;
    end
    abort_p = -1;
  endtask

  task automatic samp(input int p, input int l, input int ba, input int sa,
                      input int bb, input int sb, input bit z);
    vld[p] = 1; lo[p] = l; b1[p] = ba; s1[p] = sa; b2[p] = bb; s2[p] = sb; az[p] = z;
  endtask

  // Event-level model: find the first qualifying sample within the timeout
  // window, follow the peak until HOLD non-improving samples, and place the
  // resulting pulses on the period timeline.
  task automatic build_expect(input int thr, input int tlen, input int np);
    int st[NPM]; int sm[NPM]; int sb[NPM]; bit sz[NPM];
    int ns, q, lim, best, hold, endp, kind, m, mb;
    bit seen, gate_on;
`ifdef PREAMBLE_SEARCH_QUIET_GATE_EN
    gate_on = 1;
`else
    gate_on = 0;
`endif
    for (int p = 0; p < NPM; p++) begin
      exp_busy[p] = 0; exp_crst[p] = 0; exp_det[p] = 0; exp_tmo[p] = 0;
    end
    ns = 0;
    for (int p = FL + 1; p < np; p++) begin
      if (vld[p]) begin
        m = -1; mb = 0;
        for (int b = 0; b < NB; b++)
          if (score_of(p, b) > m) begin m = score_of(p, b); mb = b; end
        st[ns] = p; sm[ns] = m; sb[ns] = mb; sz[ns] = az[p]; ns++;
      end
    end
    q = -1; seen = 0;
    lim = (tlen == 0 || tlen > ns) ? ns : tlen;
    for (int k = 0; k < lim; k++) begin
      if (sz[k]) seen = 1;
      if ((seen || !gate_on) && sm[k] >= thr) begin q = k; break; end
    end
    endp = np; kind = 0; best = 0;
    if (q >= 0) begin
      best = q; hold = 0;
      for (int k = q + 1; k < ns; k++) begin
        if (sm[k] > sm[best]) begin best = k; hold = 0; end
        else hold++;
        if (hold == HLD) begin endp = st[k] + 2; kind = 1; break; end
      end
    end else if (tlen != 0 && ns >= tlen) begin
      endp = st[tlen-1] + 1; kind = 2;
    end
    if (abort_p >= 0 && abort_p <= endp) begin endp = abort_p; kind = 0; end
    for (int p = 1; p <= endp && p < np; p++) begin
      exp_busy[p] = 1;
      if (p <= FL && p != abort_p) exp_crst[p] = 1;
    end
    if (kind == 1 && endp < np) begin
      exp_det[endp] = 1; exp_bank = sb[best]; exp_score = sm[best]; exp_off = best;
    end
    if (kind == 2 && endp < np) exp_tmo[endp] = 1;
  endtask

  task automatic idle_inputs();
    start = 0; abort = 0; corr_vld = 0; all_zeros = 0; corr_dat = '0;
    threshold = '0; timeout_len = '0;
  endtask

  // Drive one scenario period by period; config only valid on the start cycle.
  task automatic run_scn(input int thr, input int tlen, input int np);
    build_expect(thr, tlen, np);
    det_count = 0; tmo_count = 0; tmo_per = -1; cap_bank = -1; cap_score = -1; cap_off = -1;
    for (int p = 0; p < np; p++) begin
      @(posedge clk); #1;
      per         = p;
      start       = (p == 0);
      threshold   = (p == 0) ? CW'(thr) : CW'(127);
      timeout_len = (p == 0) ? CNTW'(tlen) : CNTW'(0);
      abort       = (p == abort_p);
      corr_vld    = vld[p];
      all_zeros   = az[p];
      corr_dat    = mkdat(p);
      checking    = 1;
    end
    @(posedge clk); #1;
    checking = 0;
    idle_inputs();
  endtask

  // Per-cycle comparison against the model timeline.
  always @(negedge clk) begin
    if (checking) begin
      chk("busy", busy, exp_busy[per]);
      chk("corr_rst", corr_rst, exp_crst[per]);
      chk("det_vld", det_vld, exp_det[per]);
      chk("timeout", timeout, exp_tmo[per]);
      if (exp_det[per]) begin
        chk("det_bank", det_bank, exp_bank);
        chk("det_score", det_score, exp_score);
        chk("det_offset", det_offset, exp_off);
      end
      if (det_vld) begin
        det_count++; cap_bank = det_bank; cap_score = det_score; cap_off = det_offset;
      end
      if (timeout) begin tmo_count++; tmo_per = per; end
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_corr_rst"}, corr_rst, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_det_vld"}, det_vld, 0);
    chk({tag, "_det_bank"}, det_bank, 0);
    chk({tag, "_det_score"}, det_score, 0);
    chk({tag, "_det_offset"}, det_offset, 0);
    chk({tag, "_timeout"}, timeout, 0);
  endtask

  task automatic setup_tie();
    clr_scn();
    for (int p = 1; p <= FL; p++) samp(p, 60, -1, 0, -1, 0, 0);
    samp(FL + 1, 10, -1, 0, -1, 0, 0);
    samp(FL + 2, 10, -1, 0, -1, 0, 0);
    samp(FL + 3, 10, 3, 40, 9, 40, 0);
    for (int k = 3; k <= 10; k++) samp(FL + 1 + k, 20, -1, 0, -1, 0, 0);
  endtask

  initial begin
    rst_n = 0;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1 chk_all_zero("reset");
    rst_n = 1;

    // Tie between banks 3 and 9; flush-time samples must be ignored.
    setup_tie();
    run_scn(30, 0, 22);
    chk("tie_count", det_count, 1);
    chk("tie_bank", cap_bank, 3);
    chk("tie_score", cap_score, 40);
    chk("tie_offset", cap_off, 2);

    // Peak climb on bank 5 with a valid on every other cycle.
    clr_scn();
    for (int k = 0; k <= 20; k++) begin
      if (k == 10)      samp(FL + 1 + 2*k, 10, 5, 31, -1, 0, 0);
      else if (k == 11) samp(FL + 1 + 2*k, 10, 5, 35, -1, 0, 0);
      else if (k == 12) samp(FL + 1 + 2*k, 10, 5, 50, -1, 0, 0);
      else              samp(FL + 1 + 2*k, (k > 12) ? 40 : 10, -1, 0, -1, 0, 0);
    end
    run_scn(30, 0, 52);
    chk("climb_count", det_count, 1);
    chk("climb_bank", cap_bank, 5);
    chk("climb_score", cap_score, 50);
    chk("climb_offset", cap_off, 12);

    // Timeout after 100 sub-threshold samples.
    clr_scn();
    for (int k = 0; k < 110; k++) samp(FL + 1 + k, 10, -1, 0, -1, 0, 0);
    run_scn(30, 100, 115);
    chk("tmo_count", tmo_count, 1);
    chk("tmo_period", tmo_per, 105);
    chk("tmo_det_count", det_count, 0);

    // Abort in TRACK after three hold samples.
    clr_scn();
    samp(FL + 1, 10, -1, 0, -1, 0, 0);
    samp(FL + 2, 10, 7, 45, -1, 0, 0);
    for (int k = 2; k <= 10; k++) samp(FL + 1 + k, 20, -1, 0, -1, 0, 0);
    abort_p = 11;
    run_scn(30, 0, 16);
    chk("abort_det_count", det_count, 0);
    chk("abort_tmo_count", tmo_count, 0);

    // A fresh search after the abort completes normally.
    setup_tie();
    run_scn(30, 0, 22);
    chk("rerun_count", det_count, 1);
    chk("rerun_bank", cap_bank, 3);

    // Abort during FLUSH, then start together with abort while idle.
    clr_scn();
    abort_p = 2;
    run_scn(30, 0, 8);
    clr_scn();
    abort_p = 0;
    run_scn(30, 0, 8);
    chk("start_abort_det", det_count, 0);

    // Quiet gate: early crossing at sample 2, all_zeros at 5, crossing again at 7.
    clr_scn();
    for (int k = 0; k <= 20; k++) begin
      if (k == 2 || k == 7) samp(FL + 1 + k, 10, 2, 50, -1, 0, 0);
      else                  samp(FL + 1 + k, 10, -1, 0, -1, 0, (k == 5));
    end
    run_scn(30, 0, 30);
    chk("gate_count", det_count, 1);
    chk("gate_bank", cap_bank, 2);
`ifdef PREAMBLE_SEARCH_QUIET_GATE_EN
    chk("gate_offset", cap_off, 7);
`else
    chk("gate_offset", cap_off, 2);
`endif

    // Asynchronous reset while tracking.
    setup_tie();
    run_scn(30, 0, 11);
    #2 rst_n = 0;
    #1 chk_all_zero("midreset");
    @(posedge clk); #1 rst_n = 1;
    repeat (3) @(posedge clk);
    #1 chk_all_zero("postreset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
